cache_mem_arbiter: RTL and testbench

//  Sole master of the unified main memory; sits upstream of the I- and D-cache fill FSMs.

---
 rtl/cache_mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Sole master of unified main memory: arbitrates I-fill, D-fill and write-through stores,
// issues block reads one word per cycle into a pipelined memory, and steers returned words.
module cache_mem_arbiter #(
  parameter int WORDS   = 8,
  parameter int MEM_LAT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     icache_miss,
  input  logic [15:0]              icache_addr,
  input  logic                     dcache_miss,
  input  logic [15:0]              dcache_addr,
  input  logic                     dcache_wr_req,
  input  logic [15:0]              dcache_wr_addr,
  input  logic [15:0]              dcache_wr_data,
  input  logic [15:0]              mem_data_out,
  input  logic                     mem_data_valid,
  output logic                     mem_enable,
  output logic                     mem_wr,
  output logic [15:0]              mem_addr,
  output logic [15:0]              mem_data_in,
  output logic [15:0]              fill_data,
  output logic [$clog2(WORDS)-1:0] fill_word,
  output logic                     icache_data_valid,
  output logic                     dcache_data_valid,
  output logic                     icache_fill_done,
  output logic                     dcache_fill_done,
  output logic                     icache_busy,
  output logic                     dcache_busy,
  output logic                     wr_ack,
  output logic                     proto_err,
  output logic [1:0]               dbg_state
);

  localparam int IW  = $clog2(WORDS);
  localparam int OFF = IW + 1;
  localparam int OW  = $clog2((MEM_LAT > WORDS ? MEM_LAT : WORDS) + 1);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL_I = 2'd1,
    FILL_D = 2'd2,
    WRITE  = 2'd3
  } state_t;

  state_t          state;
  logic [15:OFF]   blk;
  logic [IW-1:0]   iss_cnt;
  logic [IW-1:0]   iss_nxt;
  logic [IW-1:0]   rcv_cnt;
  logic [OW-1:0]   out_cnt;
  logic            filling;
  logic            rd_issue;
  logic            rd_valid;
  logic            last_ret;
  logic            unused_addr_bits;

  // Handshake: every request is a level held by its requester until the matching
  // *_fill_done / wr_ack pulse, and is only sampled while the FSM sits in IDLE.
  assign filling  = (state == FILL_I) || (state == FILL_D);
  assign rd_issue = mem_enable && !mem_wr;
  // A returning word is accepted only while a read of the current fill is in flight.
  assign rd_valid = mem_data_valid && filling && (out_cnt != '0);
  assign last_ret = rd_valid && (rcv_cnt == LAST);
  assign iss_nxt  = iss_cnt + IW'(1);

  assign fill_data         = mem_data_out;
  assign fill_word         = rcv_cnt;
  assign icache_data_valid = rd_valid && (state == FILL_I);
  assign dcache_data_valid = rd_valid && (state == FILL_D);
  assign icache_fill_done  = last_ret && (state == FILL_I);
  assign dcache_fill_done  = last_ret && (state == FILL_D);
  assign icache_busy       = (state == FILL_I);
  assign dcache_busy       = (state == FILL_D) || (state == WRITE);
  assign dbg_state         = state;
  assign unused_addr_bits  = ^{icache_addr[OFF-1:0], dcache_addr[OFF-1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      blk         <= '0;
      iss_cnt     <= '0;
      rcv_cnt     <= '0;
      out_cnt     <= '0;
      mem_enable  <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_data_in <= '0;
      wr_ack      <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      wr_ack  <= 1'b0;
      out_cnt <= out_cnt + OW'(rd_issue) - OW'(rd_valid);
      if (mem_data_valid && !rd_valid) proto_err <= 1'b1;

      case (state)
        IDLE: begin
          if (dcache_wr_req) begin
            state       <= WRITE;
            mem_enable  <= 1'b1;
            mem_wr      <= 1'b1;
            mem_addr    <= dcache_wr_addr;
            mem_data_in <= dcache_wr_data;
            wr_ack      <= 1'b1;
          end else if (dcache_miss) begin
            state      <= FILL_D;
            blk        <= dcache_addr[15:OFF];
            iss_cnt    <= '0;
            rcv_cnt    <= '0;
            mem_enable <= 1'b1;
            mem_wr     <= 1'b0;
            mem_addr   <= {dcache_addr[15:OFF], {IW{1'b0}}, 1'b0};
          end else if (icache_miss) begin
            state      <= FILL_I;
            blk        <= icache_addr[15:OFF];
            iss_cnt    <= '0;
            rcv_cnt    <= '0;
            mem_enable <= 1'b1;
            mem_wr     <= 1'b0;
            mem_addr   <= {icache_addr[15:OFF], {IW{1'b0}}, 1'b0};
          end
        end
        WRITE: begin
          state      <= IDLE;
          mem_enable <= 1'b0;
          mem_wr     <= 1'b0;
        end
        FILL_I, FILL_D: begin
          if (mem_enable) begin
            if (iss_cnt == LAST) begin
              mem_enable <= 1'b0;
              iss_cnt    <= '0;
            end else begin
              iss_cnt  <= iss_nxt;
              mem_addr <= {blk, iss_nxt, 1'b0};
            end
          end
          if (rd_valid) begin
            if (last_ret) begin
              state   <= IDLE;
              rcv_cnt <= '0;
              iss_cnt <= '0;
            end else begin
              rcv_cnt <= rcv_cnt + IW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: pipelined memory model, requester drivers and a
// transaction-timeline reference model that predicts every bus cycle and returned word.
module tb_cache_mem_arbiter;

  localparam int WORDS   = 8;
  localparam int MEM_LAT = 4;
  localparam int B_EN = 9, B_WR = 8, B_IV = 7, B_DV = 6, B_ID = 5, B_DD = 4;
  localparam int B_IB = 3, B_DB = 2, B_ACK = 1, B_PE = 0;
  localparam int NEVER = 32'h7fffffff;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        icache_miss = 1'b0, dcache_miss = 1'b0, dcache_wr_req = 1'b0;
  logic [15:0] icache_addr = '0, dcache_addr = '0, dcache_wr_addr = '0, dcache_wr_data = '0;
  logic [15:0] mem_data_out = '0;
  logic        mem_data_valid = 1'b0;
  logic        mem_enable, mem_wr, icache_data_valid, dcache_data_valid;
  logic        icache_fill_done, dcache_fill_done, icache_busy, dcache_busy, wr_ack, proto_err;
  logic [15:0] mem_addr, mem_data_in, fill_data;
  logic [2:0]  fill_word;
  logic [1:0]  dbg_state;

  cache_mem_arbiter #(.WORDS(WORDS), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst),
    .icache_miss(icache_miss), .icache_addr(icache_addr),
    .dcache_miss(dcache_miss), .dcache_addr(dcache_addr),
    .dcache_wr_req(dcache_wr_req), .dcache_wr_addr(dcache_wr_addr), .dcache_wr_data(dcache_wr_data),
    .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .fill_data(fill_data), .fill_word(fill_word),
    .icache_data_valid(icache_data_valid), .dcache_data_valid(dcache_data_valid),
    .icache_fill_done(icache_fill_done), .dcache_fill_done(dcache_fill_done),
    .icache_busy(icache_busy), .dcache_busy(dcache_busy),
    .wr_ack(wr_ack), .proto_err(proto_err), .dbg_state(dbg_state)
  );

  // scoreboard state: expected per-cycle outputs keyed by cycle number
  int n_checks = 0, n_fail = 0, cyc = 0;
  logic [9:0]  exp_ctrl[int];
  logic [15:0] exp_addr[int], exp_wdata[int], exp_fdata[int];
  logic [2:0]  exp_word[int];
  logic [15:0] pend[int];
  int free_at = 0, perr_at = NEVER;
  int i_gap = 0, d_gap = 0, w_gap = 0;
  bit auto_mode = 0, rst_req = 0, stray_req = 0, prev_rst = 0;
  bit i_new = 0, d_new = 0, w_new = 0;
  logic [15:0] i_a, d_a, w_a, w_d;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], ~a[15:8]} ^ 16'h3C5A;
  endfunction

  function automatic logic [9:0] ctrl_at(input int c);
    return exp_ctrl.exists(c) ? exp_ctrl[c] : 10'd0;
  endfunction

  task automatic add_ctrl(input int c, input logic [9:0] b);
    exp_ctrl[c] = ctrl_at(c) | b;
  endtask

  // A fill granted at g reads g+1..g+WORDS, returns each word MEM_LAT later.
  task automatic sched_fill(input int g, input logic [15:0] a, input bit is_d);
    logic [15:0] base;
    logic [15:0] wa;
    int done;
    base = a & ~16'(2 * WORDS - 1);
    done = g + WORDS + MEM_LAT;
    for (int k = 0; k < WORDS; k++) begin
      wa = base + 16'(2 * k);
      add_ctrl(g + 1 + k, 10'd1 << B_EN);
      exp_addr[g + 1 + k] = wa;
      add_ctrl(g + 1 + k + MEM_LAT, 10'd1 << (is_d ? B_DV : B_IV));
      exp_word[g + 1 + k + MEM_LAT]  = 3'(k);
      exp_fdata[g + 1 + k + MEM_LAT] = mem_word(wa);
    end
    add_ctrl(done, 10'd1 << (is_d ? B_DD : B_ID));
    for (int c = g + 1; c <= done; c++) add_ctrl(c, 10'd1 << (is_d ? B_DB : B_IB));
    free_at = done + 1;
  endtask

  task automatic sched_write(input int g, input logic [15:0] a, input logic [15:0] d);
    add_ctrl(g + 1, (10'd1 << B_EN) | (10'd1 << B_WR) | (10'd1 << B_ACK) | (10'd1 << B_DB));
    exp_addr[g + 1]  = a;
    exp_wdata[g + 1] = d;
    free_at = g + 2;
  endtask

  // driver: one clock cycle of stimulus, model update and output comparison
  task automatic step();
    logic [9:0] pc, ec, got;
    @(posedge clk);
    #1;
    cyc++;
    prev_rst = rst;
    rst = rst_req;
    rst_req = 0;
    if (prev_rst) begin
      pend.delete();
      perr_at = NEVER;
    end
    mem_data_valid = pend.exists(cyc) || stray_req;
    mem_data_out   = pend.exists(cyc) ? mem_word(pend[cyc]) : (stray_req ? 16'hDEAD : 16'h0000);
    if (pend.exists(cyc)) pend.delete(cyc);

    pc = ctrl_at(cyc - 1);
    if (pc[B_ID])  begin icache_miss = 0;   i_gap = $urandom_range(1, 6); end
    if (pc[B_DD])  begin dcache_miss = 0;   d_gap = $urandom_range(1, 6); end
    if (pc[B_ACK]) begin dcache_wr_req = 0; w_gap = $urandom_range(1, 6); end
    if (i_new) begin icache_miss = 1; icache_addr = i_a; i_new = 0; end
    if (d_new) begin dcache_miss = 1; dcache_addr = d_a; d_new = 0; end
    if (w_new) begin dcache_wr_req = 1; dcache_wr_addr = w_a; dcache_wr_data = w_d; w_new = 0; end
    if (auto_mode && !rst) begin
      if (!icache_miss) begin
        if (i_gap > 0) i_gap--;
        else if ($urandom_range(0, 7) == 0) begin icache_miss = 1; icache_addr = 16'($urandom); end
      end
      if (!dcache_miss) begin
        if (d_gap > 0) d_gap--;
        else if ($urandom_range(0, 7) == 0) begin dcache_miss = 1; dcache_addr = 16'($urandom); end
      end
      if (!dcache_wr_req) begin
        if (w_gap > 0) w_gap--;
        else if ($urandom_range(0, 9) == 0) begin
          dcache_wr_req = 1; dcache_wr_addr = 16'($urandom); dcache_wr_data = 16'($urandom);
        end
      end
    end
    if (rst) begin
      icache_miss = 0; dcache_miss = 0; dcache_wr_req = 0;
      for (int c = cyc + 1; c <= cyc + WORDS + MEM_LAT + 4; c++) begin
        exp_ctrl.delete(c); exp_addr.delete(c); exp_wdata.delete(c);
        exp_fdata.delete(c); exp_word.delete(c);
      end
      free_at = cyc + 1;
    end else begin
      if (stray_req && perr_at > cyc + 1) perr_at = cyc + 1;
      if (cyc >= free_at) begin
        if (dcache_wr_req)    sched_write(cyc, dcache_wr_addr, dcache_wr_data);
        else if (dcache_miss) sched_fill(cyc, dcache_addr, 1'b1);
        else if (icache_miss) sched_fill(cyc, icache_addr, 1'b0);
      end
    end
    stray_req = 0;

    @(negedge clk);
    ec = ctrl_at(cyc);
    ec[B_PE] = (cyc >= perr_at);
    got = {mem_enable, mem_wr, icache_data_valid, dcache_data_valid, icache_fill_done,
           dcache_fill_done, icache_busy, dcache_busy, wr_ack, proto_err};
    check("ctrl", 32'(got), 32'(ec));
    if (ec[B_EN]) check("mem_addr", 32'(mem_addr), 32'(exp_addr[cyc]));
    if (ec[B_WR]) check("mem_data_in", 32'(mem_data_in), 32'(exp_wdata[cyc]));
    if (ec[B_IV] || ec[B_DV]) begin
      check("fill_word", 32'(fill_word), 32'(exp_word[cyc]));
      check("fill_data", 32'(fill_data), 32'(exp_fdata[cyc]));
    end
    if (prev_rst) check("rst_out", {mem_addr, mem_data_in}, 32'd0);
    if (!rst && mem_enable && !mem_wr) pend[cyc + MEM_LAT] = mem_addr;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    run(3);
    // single I fill from an unaligned address
    i_a = 16'h1234; i_new = 1;
    run(20);
    // simultaneous misses: D first, then I
    i_a = 16'h0a50; d_a = 16'h7f3e; i_new = 1; d_new = 1;
    run(40);
    // store beats D miss
    w_a = 16'h2002; w_d = 16'hBEEF; d_a = 16'h4000; w_new = 1; d_new = 1;
    run(25);
    // store raised mid I fill waits for the fill
    i_a = 16'hc00e; i_new = 1;
    run(6);
    w_a = 16'h3001; w_d = 16'h1357; w_new = 1;
    run(25);
    // reset on the third returned word, then restart
    i_a = 16'h8000; i_new = 1;
    run(7);
    rst_req = 1;
    run(3);
    i_a = 16'h8000; i_new = 1;
    run(20);
    // stray memory data in IDLE
    stray_req = 1;
    run(4);
    rst_req = 1;
    run(3);
    // random traffic, then drain
    auto_mode = 1;
    run(2500);
    auto_mode = 0;
    run(60);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
